// File: rtl/clustering_pkg.sv
// ============================================================================
// Module      : clustering_pkg
// Description : Shared types and default sizes for the clustering blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clustering_pkg;

    localparam int N_DEFAULT  = 16;
    localparam int LW_DEFAULT = 4;

    localparam logic KIND_POINT   = 1'b0;
    localparam logic KIND_SUMMARY = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SUMM = 2'd2,
        ST_FIN  = 2'd3
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/cluster_count_bank.sv
// ============================================================================
// Module      : cluster_count_bank
// Description : Per-label population counters: clear, increment-at-label,
//               combinational read-at-k.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cluster_count_bank
    import clustering_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int LW = LW_DEFAULT,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_inc_en,
    input  logic [LW-1:0] i_inc_label,
    input  logic [LW-1:0] i_rd_k,
    output logic [CW-1:0] o_rd_count
);

    logic [CW-1:0] r_cnt [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else if (i_inc_en) begin
            r_cnt[i_inc_label] <= r_cnt[i_inc_label] + CW'(1);
        end
    end

    assign o_rd_count = r_cnt[i_rd_k];

endmodule

`default_nettype wire

// File: rtl/cluster_label_readout.sv
// ============================================================================
// Module      : cluster_label_readout
// Description : Scans the label RAM, streams (point, label) beats and then one
//               population beat per cluster. Option: CLUSTER_SKIP_UNLABELED_EN
//               suppresses point beats whose label is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cluster_label_readout
    import clustering_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int LW = LW_DEFAULT,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [LW-1:0] raddr,
    input  logic [LW-1:0] rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_kind,
    output logic [LW-1:0] out_idx,
    output logic [LW-1:0] out_label,
    output logic [CW-1:0] out_count,
    output logic [LW-1:0] num_clusters,
    output logic          busy,
    output logic          done
);

    rd_state_t     r_state;
    logic [LW-1:0] r_idx;
    logic [LW-1:0] r_k;
    logic [LW-1:0] r_nc;
    logic          r_out_valid;
    logic          r_out_kind;
    logic [LW-1:0] r_out_idx;
    logic [LW-1:0] r_out_label;
    logic [CW-1:0] r_out_count;
    logic          r_done;

    logic          w_slot_free;
    logic          w_scan_step;
    logic          w_emit_point;
    logic [LW-1:0] w_nc_next;
    logic [CW-1:0] w_k_count;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_scan_step = (r_state == ST_SCAN) && w_slot_free;
    assign w_nc_next   = (rdata > r_nc) ? rdata : r_nc;

`ifdef CLUSTER_SKIP_UNLABELED_EN
    assign w_emit_point = (rdata != '0);
`else
    assign w_emit_point = 1'b1;
`endif

    cluster_count_bank #(
        .N  (N),
        .LW (LW),
        .CW (CW)
    ) u_count_bank (
        .clk         (clk),
        .rst         (rst),
        .i_clear     ((r_state == ST_IDLE) && start),
        .i_inc_en    (w_scan_step),
        .i_inc_label (rdata),
        .i_rd_k      (r_k),
        .o_rd_count  (w_k_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_k         <= '0;
            r_nc        <= '0;
            r_out_valid <= 1'b0;
            r_out_kind  <= KIND_POINT;
            r_out_idx   <= '0;
            r_out_label <= '0;
            r_out_count <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_nc    <= '0;
                        r_idx   <= '0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_slot_free) begin
                        r_nc <= w_nc_next;
                        if (w_emit_point) begin
                            r_out_valid <= 1'b1;
                            r_out_kind  <= KIND_POINT;
                            r_out_idx   <= r_idx;
                            r_out_label <= rdata;
                            r_out_count <= '0;
                        end else begin
                            r_out_valid <= 1'b0;
                        end
                        // idx returns to 0 so raddr rests at 0 outside SCAN; an
                        // all-unlabeled scan has no summaries and skips SUMM.
                        if (r_idx == LW'(N - 1)) begin
                            r_idx   <= '0;
                            r_k     <= LW'(1);
                            r_state <= (w_nc_next == '0) ? ST_FIN : ST_SUMM;
                        end else begin
                            r_idx <= r_idx + LW'(1);
                        end
                    end
                end
                ST_SUMM: begin
                    if (r_nc == '0) begin
                        r_state <= ST_FIN;
                    end else if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_kind  <= KIND_SUMMARY;
                        r_out_idx   <= r_k;
                        r_out_label <= r_k;
                        r_out_count <= w_k_count;
                        if (r_k == r_nc) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_k <= r_k + LW'(1);
                        end
                    end
                end
                ST_FIN: begin
                    if (w_slot_free) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_k         <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign raddr        = r_idx;
    assign out_valid    = r_out_valid;
    assign out_kind     = r_out_kind;
    assign out_idx      = r_out_idx;
    assign out_label    = r_out_label;
    assign out_count    = r_out_count;
    assign num_clusters = r_nc;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_cluster_label_readout.sv
// ============================================================================
// Module      : tb_cluster_label_readout
// Description : Self-checking bench for cluster_label_readout against a
//               list-based reference of the expected beat stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cluster_label_readout;
    import clustering_pkg::*;

    localparam int N  = 16;
    localparam int LW = 4;
    localparam int CW = 5;

    typedef struct packed {
        logic          kind;
        logic [LW-1:0] idx;
        logic [LW-1:0] label;
        logic [CW-1:0] count;
    } beat_t;

    typedef struct {
        logic [LW-1:0] lab [N];
        int            exp_nc;
        int            exp_beats;
        int            exp_lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [LW-1:0] raddr;
    logic [LW-1:0] rdata;
    logic          out_valid;
    logic          out_kind;
    logic [LW-1:0] out_idx;
    logic [LW-1:0] out_label;
    logic [CW-1:0] out_count;
    logic [LW-1:0] num_clusters;
    logic          busy;
    logic          done;

    logic [LW-1:0] mem [N];
    beat_t         exp_q [$];
    beat_t         got_q [$];
    vec_t          vecs [5];
    int            n_cmp = 0;
    int            n_bad = 0;

    assign rdata = mem[raddr];

    always #5 clk = ~clk;

    cluster_label_readout #(.N(N), .LW(LW), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .raddr        (raddr),
        .rdata        (rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_kind     (out_kind),
        .out_idx      (out_idx),
        .out_label    (out_label),
        .out_count    (out_count),
        .num_clusters (num_clusters),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk the label list, tally populations, then list clusters 1..max.
    task automatic build_model(output int nc);
        int cnt [N];
        exp_q.delete();
        nc = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int i = 0; i < N; i++) begin
            int l;
            l = int'(mem[i]);
`ifdef CLUSTER_SKIP_UNLABELED_EN
            if (l != 0)
`endif
                exp_q.push_back('{1'b0, LW'(i), LW'(l), CW'(0)});
            cnt[l]++;
            if (l > nc) nc = l;
        end
        for (int k = 1; k <= nc; k++)
            exp_q.push_back('{1'b1, LW'(k), LW'(k), CW'(cnt[k])});
    endtask

    // mode 0: ready high, 1: random ready, 2: 3-cycle stall on point 5,
    // 3: ready high with a stray start pulse mid-scan.
    // exp_nc < 0 takes the expectations from the reference model.
    task automatic run_readout(input string tag, input int mode, input int exp_nc_in,
                               input int exp_beats_in, input int exp_lat_in);
        int    mnc, exp_nc, exp_beats, exp_lat, lat, ndone, stall_left, iter, nchk;
        bit    seen5, prev_stall;
        beat_t prev, cur;
        build_model(mnc);
        exp_nc    = (exp_nc_in < 0) ? mnc : exp_nc_in;
        exp_beats = (exp_nc_in < 0) ? exp_q.size() : exp_beats_in;
        exp_lat   = (exp_nc_in < 0) ? N + mnc + 2 : exp_lat_in;
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        iter = 0; ndone = 0; lat = -1; stall_left = 0; seen5 = 1'b0; prev_stall = 1'b0;
        prev = '0;
        while (iter < 300 && ndone == 0) begin
            case (mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!seen5 && out_valid && !out_kind && out_idx == 4'd5) begin
                        seen5 = 1'b1;
                        stall_left = 3;
                    end
                    out_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                3: begin
                    out_ready = 1'b1;
                    start = (iter == 5);
                end
                default: out_ready = 1'b1;
            endcase
            #1;
            cur = '{out_kind, out_idx, out_label, out_count};
            if (prev_stall) begin
                check($sformatf("%s hold_beat", tag), 64'(cur), 64'(prev));
                check($sformatf("%s hold_valid", tag), 64'(out_valid), 64'd1);
            end
            if (mode == 2 && out_valid && !out_ready)
                check($sformatf("%s stall_raddr", tag), 64'(raddr), 64'd6);
            if (out_valid && out_ready) got_q.push_back(cur);
            prev_stall = out_valid && !out_ready;
            prev = cur;
            if (done) begin
                ndone++;
                lat = iter + 1;
            end
            iter++;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        #1;
        check($sformatf("%s done_seen", tag), 64'(ndone), 64'd1);
        check($sformatf("%s done_pulse_width", tag), 64'(done), 64'd0);
        check($sformatf("%s busy_after", tag), 64'(busy), 64'd0);
        check($sformatf("%s num_clusters", tag), 64'(num_clusters), 64'(exp_nc));
        check($sformatf("%s beat_count", tag), 64'(got_q.size()), 64'(exp_beats));
        if (mode == 0 || mode == 3)
            check($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat));
        nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++)
            check($sformatf("%s beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        // Test patterns with hand-derived expectations.
        for (int v = 0; v < 5; v++)
            for (int i = 0; i < N; i++) vecs[v].lab[i] = '0;
        vecs[0].lab[0] = 4'd1; vecs[0].lab[1] = 4'd1; vecs[0].lab[2] = 4'd2;
        vecs[0].exp_nc = 2; vecs[0].exp_lat = 20;
        vecs[1].exp_nc = 0; vecs[1].exp_lat = 18;
        for (int i = 0; i < N; i++) vecs[2].lab[i] = 4'd5;
        vecs[2].exp_nc = 5; vecs[2].exp_lat = 23;
        for (int i = 0; i < N; i++) vecs[3].lab[i] = LW'(i);
        vecs[3].exp_nc = 15; vecs[3].exp_lat = 33;
        for (int i = 1; i < N; i += 2) vecs[4].lab[i] = 4'd3;
        vecs[4].exp_nc = 3; vecs[4].exp_lat = 21;
`ifdef CLUSTER_SKIP_UNLABELED_EN
        vecs[0].exp_beats = 5;  vecs[1].exp_beats = 0;  vecs[2].exp_beats = 21;
        vecs[3].exp_beats = 30; vecs[4].exp_beats = 11;
`else
        vecs[0].exp_beats = 18; vecs[1].exp_beats = 16; vecs[2].exp_beats = 21;
        vecs[3].exp_beats = 31; vecs[4].exp_beats = 19;
`endif

        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              64'({raddr, out_valid, out_kind, out_idx, out_label, out_count,
                   num_clusters, busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++) mem[i] = vecs[v].lab[i];
            run_readout($sformatf("vec%0d", v), 0, vecs[v].exp_nc,
                        vecs[v].exp_beats, vecs[v].exp_lat);
        end

        for (int i = 0; i < N; i++) mem[i] = vecs[0].lab[i];
        run_readout("restart_ignored", 3, vecs[0].exp_nc, vecs[0].exp_beats, vecs[0].exp_lat);

        for (int i = 0; i < N; i++) mem[i] = vecs[3].lab[i];
        run_readout("backpressure", 2, vecs[3].exp_nc, vecs[3].exp_beats, vecs[3].exp_lat);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) mem[i] = LW'($urandom_range(0, 7));
            run_readout($sformatf("rand%0d", r), (r % 2 == 0) ? 1 : 0, -1, 0, 0);
        end

        // Reset in the middle of the summary phase.
        begin
            bit reached;
            int ndone;
            for (int i = 0; i < N; i++) mem[i] = vecs[3].lab[i];
            reached = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 60 && !reached; i++) begin
                #1;
                if (out_valid && out_kind) reached = 1'b1;
                else @(negedge clk);
            end
            check("summ_reached", 64'(reached), 64'd1);
            rst = 1'b1;
            #1;
            check("mid_reset_outputs",
                  64'({raddr, out_valid, out_kind, out_idx, out_label, out_count,
                       num_clusters, busy, done}), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            ndone = 0;
            repeat (4) begin
                @(negedge clk);
                #1;
                if (done || busy) ndone++;
            end
            check("no_done_after_reset", 64'(ndone), 64'd0);
            for (int i = 0; i < N; i++) mem[i] = vecs[0].lab[i];
            run_readout("after_reset", 0, vecs[0].exp_nc, vecs[0].exp_beats, vecs[0].exp_lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cluster_label_readout.md
# cluster_label_readout

Drains the point-label memory once the clustering FSM has finished writing it. The block scans addresses 0..N-1 over the same combinational label read port the FSM uses, then streams every (point, label) pair downstream on a valid/ready interface. It follows that with one summary beat per cluster, giving the cluster's point count. It sits between the label RAM and the host/UART export path, and is started by the FSM's `done`.

## Interface
- `N`, 16: number of points; the label RAM depth.
- `LW`, 4: width of labels and indices. Label 0 means unlabeled.
- `CW`, $clog2(N+1) = 5: width of the count field.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle pulse that begins a readout. Sampled only in IDLE.
- `raddr`, output, LW: label RAM read address.
- `rdata`, input, LW: label at `raddr`, combinational, same cycle.
- `out_valid`, output, 1: output beat is valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_kind`, output, 1: 0 = point beat, 1 = summary beat.
- `out_idx`, output, LW: point index (point beat) or cluster id (summary beat).
- `out_label`, output, LW: point's label (point beat) or cluster id (summary beat).
- `out_count`, output, CW: 0 on point beats; cluster population on summary beats.
- `num_clusters`, output, LW: highest label seen during the current or last scan.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse after the final beat is accepted.

## Operation
- States are IDLE, SCAN, SUMM and FIN.
- IDLE:
  - `raddr` = 0.
  - On `start`: clear all counts and `num_clusters`, set `idx` = 0, go to SCAN.
- SCAN:
  - `raddr` = `idx`.
  - Load condition is "slot free" = `!out_valid || out_ready`. When the slot is free, register one point beat (kind 0, `idx`, `rdata`, count 0) and set `out_valid` = 1.
  - On load, increment `cnt[rdata]` and set `num_clusters` = max(`num_clusters`, `rdata`).
  - On load with `idx` == N-1, go to SUMM with `k` = 1. Otherwise `idx` += 1.
- SUMM:
  - If `num_clusters` == 0, go straight to FIN.
  - Otherwise, when the slot is free, load a summary beat (kind 1, `k`, `k`, `cnt[k]`).
  - After loading `k` == `num_clusters`, go to FIN. Otherwise `k` += 1.
  - Clusters with a zero count inside 1..`num_clusters` are still emitted, with count 0.
- FIN:
  - Wait until `out_valid` is 0 or is being accepted in this cycle.
  - Then pulse `done`, drop `out_valid`, go to IDLE.
- Handshake:
  - A beat transfers on `out_valid && out_ready`.
  - While `out_valid && !out_ready`, all `out_*` fields hold stable. `raddr` does not advance, and no count changes.
  - `out_valid` never drops without a transfer, except on reset.
- Arithmetic: counts are CW bits wide and cannot overflow, since the total is at most N. `cnt[0]` is accumulated but never emitted.
- `start` outside IDLE is ignored.
- `rst` at any time:
  - State goes to IDLE.
  - All outputs, counts, `idx`, `k` and `num_clusters` clear to 0.
  - Any partial readout is lost; no `done` is issued.

## Timing
- Reset values: `raddr` 0, `out_valid` 0, `out_kind` 0, `out_idx` 0, `out_label` 0, `out_count` 0, `num_clusters` 0, `busy` 0, `done` 0.
- `start` sampled at edge E0 → SCAN from E0, `raddr` = 0 → first point beat valid after E1.
- With `out_ready` held high, one beat per cycle. Point k is valid after edge E(k+1).
- With `out_ready` held high, total duration from `start` to `done` = N + `num_clusters` + 2 cycles. `done` is high for exactly one cycle.
- `rdata` is sampled only on a load edge in SCAN. The label RAM must not be written while `busy` is high.

## Configuration
- Macro: `CLUSTER_SKIP_UNLABELED_EN`.
- Defined: SCAN emits no point beat for points whose label is 0.
  - Their count and `idx` still advance.
  - The scan costs one cycle per skipped point with `out_valid` unchanged by it.
- Undefined: all N point beats are emitted, including label 0.

## Structure
- Shared package `clustering_pkg` holds:
  - the state enum `rd_state_t` (IDLE, SCAN, SUMM, FIN);
  - `KIND_POINT` = 0 and `KIND_SUMMARY` = 1;
  - the default `N`/`LW` constants, shared with `clustering_fsm`.
- One sub-module, `cluster_count_bank`: N×CW counter array with a clear input, an increment-at-label port and a combinational read-at-k port.

## Test plan
- Labels [1,1,2,0,…0] (N=16), macro undefined, `out_ready`=1 → 16 point beats in index order with labels as stored, then summary beats (1,count 2) and (2,count 1), `num_clusters`=2, `done` 20 cycles after `start`.
- All labels 0 → 16 point beats with label 0, no summary beats, `num_clusters`=0, `done` after 18 cycles.
- Backpressure: `out_ready` low for 3 cycles on point 5 → beat 5 stays stable, `raddr` frozen at 6, no beat lost or duplicated, final counts unchanged.
- `start` re-pulsed mid-SCAN → ignored, sequence identical to the first run.
- `rst` asserted during SUMM → all outputs 0 next cycle, no `done`; a fresh `start` gives a full, correct readout.
- Macro defined, labels [0,3,0,3,…] with odd indices = 3 → only 8 point beats (odd indices), then summary beats (1,0), (2,0), (3,8).
